lsu_ctrl: RTL and testbench

- Load/store initiator that sits between the CPU MEM stage and the byte-lane data memory.
- Accepts one request at a time over a valid/ready handshake and checks alignment and range.
- Drives the memory's addr/din/we/byte-select/ext-select pins and returns one response pulse per request.
- The memory only supports byte or word accesses, so halfword accesses are split into two sequential byte accesses (little-endian).

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_ctrl_if.sv | 53 +++++
 rtl/lsu_align.sv | 38 +++
 rtl/lsu_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store controller: access-size
//               encodings, FSM state type and the request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access-size encodings as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Returns 1 when a request must be rejected: illegal size, misaligned word,
  // or any touched byte lying beyond the last memory word. A halfword only
  // needs byte alignment because it is issued as two byte accesses, so its
  // second byte (addr+1) is range-checked separately.
  function automatic logic lsu_req_err(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input int          mem_words);
    logic [31:0] addr_nxt;
    logic [31:0] lim;
    logic        err;
    addr_nxt = addr + 32'd1;
    lim      = 32'(mem_words);
    err      = 1'b0;
    if (size == SZ_ILL) err = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) err = 1'b1;
    if ({2'b00, addr[31:2]} >= lim) err = 1'b1;
    if ((size == SZ_HALF) && ({2'b00, addr_nxt[31:2]} >= lim)) err = 1'b1;
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_req_if / lsu_mem_if
// Description : Bus bundles for the load/store controller.
//               lsu_req_if : CPU-side request/response handshake.
//                 master = CPU (drives req_*), slave = controller.
//               lsu_mem_if : byte-lane data memory pins.
//                 master = controller (drives addr/din/we/B/ExtOp),
//                 slave  = memory (drives dout).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_B;
  logic        mem_ExtOp;
  logic [31:0] mem_dout;

  modport master (
    output mem_addr, mem_din, mem_we, mem_B, mem_ExtOp,
    input  mem_dout
  );

  modport slave (
    input  mem_addr, mem_din, mem_we, mem_B, mem_ExtOp,
    output mem_dout
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational read-data formatter. Produces the load result
//               from the memory read data for the current access size.
// Ports       : size_i   - access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//               sign_i   - 1 = sign-extend, 0 = zero-extend
//               byte0_i  - low byte of a halfword, captured by the first access
//               dout_i   - memory read data of the current access
//               rdata_o  - formatted load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [7:0]  byte0_i,
  input  logic [31:0] dout_i,
  output logic [31:0] rdata_o
);

  // The second half access is a byte read, so the high byte of the halfword
  // arrives in the low lane of dout.
  logic [15:0] w_half;
  assign w_half = {dout_i[7:0], byte0_i};

  always_comb begin
    rdata_o = dout_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sign_i & dout_i[7]}}, dout_i[7:0]};
      SZ_HALF: rdata_o = {{16{sign_i & w_half[15]}}, w_half};
      default: rdata_o = dout_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store initiator between the CPU MEM stage and a byte-lane
//               data memory. One request at a time; checks alignment/range,
//               drives registered memory pins and returns one response pulse.
//               Halfwords are split into two little-endian byte accesses.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               req (slave)   - request/response handshake
//               mem (master)  - memory addr/din/we/B/ExtOp, dout returned
//               stat_loads/stat_stores/stat_errs - saturating counters,
//                               present only when LSU_STATS_EN is defined
// Config      : `define LSU_STATS_EN to add the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 128,
  parameter int STAT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_req_if.slave         req,
  lsu_mem_if.master        mem
`ifdef LSU_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic        sign_q, sign_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  wdata_hi_q, wdata_hi_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_b_q, mem_b_d;
  logic        mem_ext_q, mem_ext_d;
  logic [31:0] w_load_data;
  logic        w_req_err;

  assign w_req_err = lsu_req_err(req.req_size, req.req_addr, MEM_WORDS);

  lsu_align u_align (
    .size_i  (size_q),
    .sign_i  (sign_q),
    .byte0_i (byte0_q),
    .dout_i  (mem.mem_dout),
    .rdata_o (w_load_data)
  );

  // --------------------------------------------------------------------------
  // State register. Every memory pin is a flop so it is stable across the
  // negedge at which the memory commits writes; reset drops mem_we at once.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= SZ_BYTE;
      wdata_hi_q <= 8'h00;
      byte0_q    <= 8'h00;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_din_q  <= 32'h0;
      mem_we_q   <= 1'b0;
      mem_b_q    <= 1'b0;
      mem_ext_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      sign_q     <= sign_d;
      size_q     <= size_d;
      wdata_hi_q <= wdata_hi_d;
      byte0_q    <= byte0_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      mem_b_q    <= mem_b_d;
      mem_ext_q  <= mem_ext_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    sign_d     = sign_q;
    size_d     = size_q;
    wdata_hi_d = wdata_hi_q;
    byte0_d    = byte0_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;
    mem_b_d    = mem_b_q;
    mem_ext_d  = mem_ext_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          // Request fields are captured here and never looked at again.
          we_d       = req.req_we;
          sign_d     = req.req_sign;
          size_d     = req.req_size;
          wdata_hi_d = req.req_wdata[15:8];
          rdata_d    = 32'h0;
          if (w_req_err) begin
            err_d    = 1'b1;
            mem_we_d = 1'b0;
            state_d  = RESP;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = req.req_addr;
            mem_we_d   = req.req_we;
            mem_b_d    = (req.req_size != SZ_WORD);
            // Halfword bytes are merged and extended here, so the memory
            // returns them raw; only a single byte load uses the memory's
            // own extension.
            mem_ext_d  = (req.req_size == SZ_BYTE) && req.req_sign;
            mem_din_d  = (req.req_size == SZ_WORD) ? req.req_wdata
                                                   : {24'h0, req.req_wdata[7:0]};
            state_d    = ACC0;
          end
        end
      end

      ACC0: begin
        if (size_q == SZ_HALF) begin
          byte0_d    = mem.mem_dout[7:0];
          mem_addr_d = mem_addr_q + 32'd1;
          mem_din_d  = {24'h0, wdata_hi_q};
          state_d    = ACC1;
        end else begin
          rdata_d  = we_q ? 32'h0 : w_load_data;
          mem_we_d = 1'b0;
          state_d  = RESP;
        end
      end

      ACC1: begin
        rdata_d  = we_q ? 32'h0 : w_load_data;
        mem_we_d = 1'b0;
        state_d  = RESP;
      end

      RESP: begin
        err_d   = 1'b0;
        rdata_d = 32'h0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_rdata = rdata_q;
  assign req.resp_err   = err_q;

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_din   = mem_din_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_B     = mem_b_q;
  assign mem.mem_ExtOp = mem_ext_q;

`ifdef LSU_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating completion counters, bumped once per response.
  // --------------------------------------------------------------------------
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [STAT_W-1:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (state_q == RESP) begin
      if (err_q) begin
        if (errs_q != STAT_MAX) errs_q <= errs_q + STAT_ONE;
      end else if (we_q) begin
        if (stores_q != STAT_MAX) stores_q <= stores_q + STAT_ONE;
      end else begin
        if (loads_q != STAT_MAX) loads_q <= loads_q + STAT_ONE;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with a byte-lane memory
//               model and a reference byte array. Expected responses are
//               queued when a request is driven and compared when the DUT
//               responds. Statistics checks are active with LSU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int MEM_WORDS = 128;

  logic clk;
  logic rst_n;

  lsu_req_if req_bus();
  lsu_mem_if mem_bus();

`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
  int exp_loads, exp_stores, exp_errs;
`endif

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS), .STAT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_bus),
    .mem   (mem_bus)
`ifdef LSU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ memory model
  bit [7:0]    mem_arr [0:511];
  bit [7:0]    ref_arr [0:511];
  logic [31:0] w_maddr;
  assign w_maddr = mem_bus.mem_addr;

  always_comb begin
    if (mem_bus.mem_B)
      mem_bus.mem_dout = {{24{mem_bus.mem_ExtOp & mem_arr[w_maddr[8:0]][7]}},
                          mem_arr[w_maddr[8:0]]};
    else
      mem_bus.mem_dout = {mem_arr[{w_maddr[8:2], 2'b11}], mem_arr[{w_maddr[8:2], 2'b10}],
                          mem_arr[{w_maddr[8:2], 2'b01}], mem_arr[{w_maddr[8:2], 2'b00}]};
  end

  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      if (mem_bus.mem_B) begin
        mem_arr[w_maddr[8:0]] <= mem_bus.mem_din[7:0];
      end else begin
        mem_arr[{w_maddr[8:2], 2'b00}] <= mem_bus.mem_din[7:0];
        mem_arr[{w_maddr[8:2], 2'b01}] <= mem_bus.mem_din[15:8];
        mem_arr[{w_maddr[8:2], 2'b10}] <= mem_bus.mem_din[23:16];
        mem_arr[{w_maddr[8:2], 2'b11}] <= mem_bus.mem_din[31:24];
      end
    end
  end

  // --------------------------------------------------------------- scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
    logic        chk_b;
    logic        b;
  } exp_t;

  exp_t sb_q[$];

  int   cyc     = 0;
  int   acc_cyc = -1;
  int   we_cnt  = 0;
  logic first_b = 1'b0;
  logic prev_rv = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (req_bus.req_valid && req_bus.req_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc == acc_cyc) begin
      we_cnt  = int'(mem_bus.mem_we);
      first_b = mem_bus.mem_B;
    end else if (mem_bus.mem_we) begin
      we_cnt = we_cnt + 1;
    end
    if (prev_rv) check_eq("resp_pulse_width", {31'h0, req_bus.resp_valid}, 32'h0);
    if (req_bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_resp", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_rdata", req_bus.resp_rdata, e.rdata);
        check_eq("resp_err", {31'h0, req_bus.resp_err}, {31'h0, e.err});
        check_eq("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        check_eq("mem_we_cycles", 32'(we_cnt), 32'(e.we_cyc));
        if (e.chk_b) check_eq("mem_B", {31'h0, first_b}, {31'h0, e.b});
      end
    end
    prev_rv = req_bus.resp_valid;
  end

  // ------------------------------------------------------------------ driver
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic        err;
    logic [31:0] a1;
    logic [7:0]  b;
    logic [15:0] h;
    int          budget;
    a1  = addr + 32'd1;
    err = (size == 2'b11) || ((size == 2'b10) && (addr[1:0] != 2'b00)) ||
          (addr[31:2] >= 30'(MEM_WORDS)) ||
          ((size == 2'b01) && (a1[31:2] >= 30'(MEM_WORDS)));
    e.err    = err;
    e.rdata  = 32'h0;
    e.lat    = err ? 1 : ((size == 2'b01) ? 3 : 2);
    e.we_cyc = (err || !we) ? 0 : ((size == 2'b01) ? 2 : 1);
    e.chk_b  = !err;
    e.b      = (size != 2'b10);
    if (!err) begin
      if (we) begin
        case (size)
          2'b00: ref_arr[addr[8:0]] = wdata[7:0];
          2'b01: begin
            ref_arr[addr[8:0]] = wdata[7:0];
            ref_arr[a1[8:0]]   = wdata[15:8];
          end
          default: begin
            ref_arr[{addr[8:2], 2'b00}] = wdata[7:0];
            ref_arr[{addr[8:2], 2'b01}] = wdata[15:8];
            ref_arr[{addr[8:2], 2'b10}] = wdata[23:16];
            ref_arr[{addr[8:2], 2'b11}] = wdata[31:24];
          end
        endcase
      end else begin
        case (size)
          2'b00: begin
            b = ref_arr[addr[8:0]];
            e.rdata = {{24{sign & b[7]}}, b};
          end
          2'b01: begin
            h = {ref_arr[a1[8:0]], ref_arr[addr[8:0]]};
            e.rdata = {{16{sign & h[15]}}, h};
          end
          default: e.rdata = {ref_arr[{addr[8:2], 2'b11}], ref_arr[{addr[8:2], 2'b10}],
                              ref_arr[{addr[8:2], 2'b01}], ref_arr[{addr[8:2], 2'b00}]};
        endcase
      end
    end
`ifdef LSU_STATS_EN
    if (err) exp_errs++;
    else if (we) exp_stores++;
    else exp_loads++;
`endif
    budget = 0;
    @(negedge clk);
    while (!req_bus.req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_bus.req_ready) begin
      check_eq("ready_timeout", 32'h0, 32'h1);
      return;
    end
    req_bus.req_we    = we;
    req_bus.req_size  = size;
    req_bus.req_sign  = sign;
    req_bus.req_addr  = addr;
    req_bus.req_wdata = wdata;
    req_bus.req_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the request fields: the controller must ignore them now.
    req_bus.req_valid = 1'b0;
    req_bus.req_we    = 1'($urandom);
    req_bus.req_size  = 2'($urandom);
    req_bus.req_sign  = 1'($urandom);
    req_bus.req_addr  = $urandom;
    req_bus.req_wdata = $urandom;
    budget = 0;
    while (sb_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      check_eq("resp_timeout", 32'h0, 32'h1);
      sb_q.delete();
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    rst_n             = 1'b0;
    req_bus.req_valid = 1'b0;
    req_bus.req_we    = 1'b0;
    req_bus.req_size  = 2'b00;
    req_bus.req_sign  = 1'b0;
    req_bus.req_addr  = 32'h0;
    req_bus.req_wdata = 32'h0;
`ifdef LSU_STATS_EN
    exp_loads  = 0;
    exp_stores = 0;
    exp_errs   = 0;
`endif
    #3;
    check_eq("rst_req_ready", {31'h0, req_bus.req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    check_eq("rst_resp_rdata", req_bus.resp_rdata, 32'h0);
    check_eq("rst_resp_err", {31'h0, req_bus.resp_err}, 32'h0);
    check_eq("rst_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
    check_eq("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check_eq("rst_mem_din", mem_bus.mem_din, 32'h0);
    check_eq("rst_mem_B", {31'h0, mem_bus.mem_B}, 32'h0);
    check_eq("rst_mem_ExtOp", {31'h0, mem_bus.mem_ExtOp}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store then load, byte loads with both extensions
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);

    // Halfword crossing a word boundary
    do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'h12348001);
    check_eq("mem_word8_b3", {24'h0, mem_arr[9'h23]}, 32'h01);
    check_eq("mem_word9_b0", {24'h0, mem_arr[9'h24]}, 32'h80);
    do_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);

    // Error cases and range boundaries
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h1FF, 32'hBEEF);
    do_req(1'b1, 2'b01, 1'b0, 32'h1FE, 32'hC3A5);
    do_req(1'b0, 2'b01, 1'b1, 32'h1FE, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h1FF, 32'h7E);
    do_req(1'b0, 2'b10, 1'b1, 32'h1FC, 32'h0);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 32'h207)), $urandom);
    end

`ifdef LSU_STATS_EN
    repeat (2) @(negedge clk);
    check_eq("stat_loads", {16'h0, stat_loads}, 32'(exp_loads));
    check_eq("stat_stores", {16'h0, stat_stores}, 32'(exp_stores));
    check_eq("stat_errs", {16'h0, stat_errs}, 32'(exp_errs));
`endif

    // Reset in the middle of a half store at 0x40
    do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h22);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_ready", {31'h0, req_bus.req_ready}, 32'h1);
    req_bus.req_we    = 1'b1;
    req_bus.req_size  = 2'b01;
    req_bus.req_sign  = 1'b0;
    req_bus.req_addr  = 32'h40;
    req_bus.req_wdata = 32'hA55A;
    req_bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_bus.req_valid = 1'b0;
    check_eq("acc0_mem_we", {31'h0, mem_bus.mem_we}, 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
    check_eq("midrst_req_ready", {31'h0, req_bus.req_ready}, 32'h1);
    check_eq("midrst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("postrst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    end
    check_eq("midrst_byte40", {24'h0, mem_arr[9'h40]}, 32'h5A);
    check_eq("midrst_byte41", {24'h0, mem_arr[9'h41]}, 32'h22);
    ref_arr[9'h40] = 8'h5A;
`ifdef LSU_STATS_EN
    check_eq("rst_stat_loads", {16'h0, stat_loads}, 32'h0);
    check_eq("rst_stat_stores", {16'h0, stat_stores}, 32'h0);
    check_eq("rst_stat_errs", {16'h0, stat_errs}, 32'h0);
    exp_loads  = 0;
    exp_stores = 0;
    exp_errs   = 0;
`endif

    // Controller still works after the interrupted access
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
